// File: rtl/microstate_sequencer.sv
// microstate_sequencer: next-state logic for the microprogrammed control unit.
// Holds the current microstate and picks the next one from the control-ROM
// next-state field: increment, jump, opcode dispatch, conditional branch,
// memory-complete wait, single-level call/return and fetch restart.
// Optional feature macro: MOC_TIMEOUT_EN. When it is defined, a bounded wait
// counter forces ILLEGAL_STATE and sets a sticky flag if moc never arrives.
module microstate_sequencer #(
  parameter int STATE_W       = 7,
  parameter int RESET_STATE   = 0,
  parameter int FETCH_STATE   = 1,
  parameter int ILLEGAL_STATE = 127,
  parameter int MOC_TIMEOUT   = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [STATE_W-1:0] state_sel,
  input  logic [2:0]         ns_ctl,
  input  logic [STATE_W-1:0] cr_addr,
  input  logic [1:0]         cond_sel,
  input  logic               cond_inv,
  input  logic [3:0]         cond_in,
  input  logic               moc,
  output logic [STATE_W-1:0] cur_state,
  output logic               illegal_op,
  output logic               moc_timeout,
  output logic               waiting
);

  typedef enum logic [2:0] {
    NS_INC      = 3'd0,
    NS_JUMP     = 3'd1,
    NS_DISPATCH = 3'd2,
    NS_CBRANCH  = 3'd3,
    NS_WAIT_MOC = 3'd4,
    NS_RETURN   = 3'd5,
    NS_CALL     = 3'd6,
    NS_FETCH    = 3'd7
  } ns_ctl_e;

  localparam logic [STATE_W-1:0] RESET_S   = STATE_W'(RESET_STATE);
  localparam logic [STATE_W-1:0] FETCH_S   = STATE_W'(FETCH_STATE);
  localparam logic [STATE_W-1:0] ILLEGAL_S = STATE_W'(ILLEGAL_STATE);

  ns_ctl_e ns;
  assign ns = ns_ctl_e'(ns_ctl);

  logic [STATE_W-1:0] cur_state_q, cur_state_d;
  logic [STATE_W-1:0] ret_q, ret_d;
  logic               illegal_op_q, illegal_op_d;
  logic [STATE_W-1:0] state_inc;
  logic               cond_bit;
  logic               wait_stall;
  logic               timeout_hit;

  // Natural wrap of the adder gives the modulo-2^STATE_W increment.
  assign state_inc  = cur_state_q + STATE_W'(1);
  assign cond_bit   = cond_in[cond_sel] ^ cond_inv;
  assign wait_stall = (ns == NS_WAIT_MOC) && !moc;
  assign waiting    = wait_stall;

`ifdef MOC_TIMEOUT_EN
  localparam int CNT_W = (MOC_TIMEOUT < 1) ? 1 : $clog2(MOC_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MOC_TIMEOUT);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             moc_timeout_q, moc_timeout_d;

  // A late moc in the final cycle wins because wait_stall already requires moc=0.
  assign timeout_hit = wait_stall && (wait_cnt_q == CNT_MAX);

  // Wait counter counts stalled cycles, clears otherwise, saturates at CNT_MAX.
  always_comb begin
    wait_cnt_d    = '0;
    moc_timeout_d = moc_timeout_q | timeout_hit;
    if (wait_stall && !timeout_hit) begin
      wait_cnt_d = (wait_cnt_q == CNT_MAX) ? wait_cnt_q : wait_cnt_q + CNT_W'(1);
    end
  end

  // Timeout state registers; moc_timeout is sticky until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q    <= '0;
      moc_timeout_q <= 1'b0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      moc_timeout_q <= moc_timeout_d;
    end
  end

  assign moc_timeout = moc_timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign moc_timeout = 1'b0;
`endif

  // Next-state, return-register and illegal-dispatch decode from ns_ctl.
  always_comb begin
    // NOTE: defaults first with blocking '=' so every path assigns every output and no latch is inferred.
    cur_state_d  = cur_state_q;
    ret_d        = ret_q;
    illegal_op_d = 1'b0;
    unique case (ns)
      NS_INC:      cur_state_d = state_inc;
      NS_JUMP:     cur_state_d = cr_addr;
      NS_DISPATCH: begin
        if (state_sel != '0) begin
          cur_state_d = state_sel;
        end else begin
          cur_state_d  = ILLEGAL_S;
          illegal_op_d = 1'b1;
        end
      end
      NS_CBRANCH:  cur_state_d = cond_bit ? cr_addr : state_inc;
      NS_WAIT_MOC: begin
        if (moc) begin
          cur_state_d = state_inc;
        end else if (timeout_hit) begin
          cur_state_d = ILLEGAL_S;
        end
      end
      NS_RETURN:   cur_state_d = ret_q;
      NS_CALL: begin
        cur_state_d = cr_addr;
        ret_d       = state_inc;
      end
      NS_FETCH:    cur_state_d = FETCH_S;
      default:     cur_state_d = cur_state_q;
    endcase
  end

  // Microstate, return address and illegal pulse registers; reset has priority.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking '<=' so all registers update together at the edge.
    if (reset) begin
      cur_state_q  <= RESET_S;
      ret_q        <= '0;
      illegal_op_q <= 1'b0;
    end else begin
      cur_state_q  <= cur_state_d;
      ret_q        <= ret_d;
      illegal_op_q <= illegal_op_d;
    end
  end

  assign cur_state  = cur_state_q;
  assign illegal_op = illegal_op_q;

endmodule

// File: doc/microstate_sequencer.md
Name: microstate_sequencer

Overview:
Next-state sequencer for the microprogrammed control unit. It holds the current microstate register and the control-ROM word's next-state field selects the following state. It consumes the 7-bit state number produced by the instruction-to-state encoder, which it uses as its dispatch target. It also sequences the memory handshake (MOC wait), conditional microbranches, and single-level call/return.

Parameters:
STATE_W, 7, width of the microstate number; must match the encoder output width.
RESET_STATE, 0, microstate loaded on reset.
FETCH_STATE, 1, first fetch microstate; target of ns_ctl=FETCH.
ILLEGAL_STATE, 127, microstate entered on dispatch of an unimplemented opcode.
MOC_TIMEOUT, 15, maximum number of WAIT_MOC cycles; used only with MOC_TIMEOUT_EN.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
state_sel  in  STATE_W  dispatch target from the instruction encoder; 0 means unimplemented opcode.
ns_ctl  in  3  next-state control field of the current control-ROM word.
cr_addr  in  STATE_W  jump/branch/call target field of the control-ROM word.
cond_sel  in  2  selects the condition bit: 0 Z, 1 N, 2 C, 3 V.
cond_inv  in  1  inverts the selected condition.
cond_in  in  4  flags {V,C,N,Z} from the datapath.
moc  in  1  memory operation complete.
cur_state  out  STATE_W  current microstate; addresses the control ROM.
illegal_op  out  1  one-cycle pulse: the dispatch hit an unimplemented opcode.
moc_timeout  out  1  sticky: a memory-wait timeout occurred.
waiting  out  1  combinational: high while ns_ctl=WAIT_MOC and moc=0.

Behaviour:
- Reset (synchronous, active-high) sets:
  - cur_state=RESET_STATE.
  - return register ret=0.
  - illegal_op=0, moc_timeout=0, wait counter=0.
- Reset has priority over every ns_ctl action, including a reset asserted in the middle of a WAIT_MOC.
- Each clock, cur_state <= next. Latency from ns_ctl/inputs to cur_state is one cycle.
- next is decoded from ns_ctl as follows:
  - 0 INC: cur_state+1, modulo 2^STATE_W (127 wraps to 0).
  - 1 JUMP: cr_addr.
  - 2 DISPATCH:
    - state_sel!=0: next = state_sel.
    - state_sel==0: next = ILLEGAL_STATE, and illegal_op=1 on the following cycle only.
  - 3 CBRANCH: c = cond_in[cond_sel] ^ cond_inv.
    - c=1: next = cr_addr.
    - c=0: next = cur_state+1 (with wrap).
  - 4 WAIT_MOC:
    - moc=1: next = cur_state+1.
    - moc=0: next = cur_state (hold).
    - A moc seen in the first WAIT_MOC cycle advances with zero stall.
  - 5 RETURN: next = ret.
  - 6 CALL: next = cr_addr, and ret <= cur_state+1 (with wrap).
    - Only one level; a nested CALL overwrites ret.
  - 7 FETCH: next = FETCH_STATE.
- ret changes only on CALL or reset; RETURN does not clear it.
- illegal_op is registered; it deasserts the cycle after it pulses unless another illegal dispatch occurs.
- Wait counter:
  - Increments in each cycle with ns_ctl=WAIT_MOC and moc=0.
  - Cleared in any other cycle.
  - Saturates at MOC_TIMEOUT; never wraps.
- moc asserted while ns_ctl!=WAIT_MOC is ignored.
- cond_in and state_sel are sampled only in the cycle they are used; nothing is latched.

Optional Feature:
MOC_TIMEOUT_EN:
- Defined:
  - When the wait counter equals MOC_TIMEOUT while in WAIT_MOC with moc=0, next = ILLEGAL_STATE.
  - moc_timeout is set and stays set until reset.
  - The counter is cleared.
  - A moc arriving in that same cycle wins: normal advance, no timeout.
- Undefined:
  - The counter logic is absent, moc_timeout is tied to 0, and WAIT_MOC holds indefinitely.

Test Plan:
- Reset then 3 cycles of INC -> cur_state 0,1,2,3. Force cur_state=127 via JUMP cr_addr=127, then INC -> 0.
- DISPATCH with state_sel=13 -> cur_state=13 next cycle, illegal_op=0. DISPATCH with state_sel=0 -> cur_state=127, illegal_op high for exactly 1 cycle.
- CBRANCH cond_sel=0, cond_inv=0, cr_addr=40, from state 11:
  - Z=1 -> 40.
  - Z=0 -> 12.
  - Z=0 with cond_inv=1 -> 40.
- WAIT_MOC at state 8 with moc low for 4 cycles, then high -> cur_state holds 8 for 4 cycles and waiting=1, then 9.
- CALL cr_addr=50 from state 20 -> 50, ret=21. Then JUMP 60, RETURN -> 21. Reset asserted mid-WAIT_MOC -> cur_state=0 next cycle.
- MOC_TIMEOUT_EN defined, moc held low in WAIT_MOC at state 8 -> cur_state=127 after MOC_TIMEOUT+1 cycles, moc_timeout=1 until reset. Without the macro -> holds 8 indefinitely, moc_timeout=0.
